// File: rtl/fnd_scan_receiver.sv
// Recovers a 4-digit decimal value from a multiplexed active-low 7-segment scan (fnd_com/fnd).
// Optional decimal-point capture is enabled by defining FND_SCAN_RECEIVER_DP_EN.
module fnd_scan_receiver #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd,
    output logic [13:0] o_value,
    output logic        o_valid,
    output logic        o_error,
    output logic [3:0]  o_dp
);

    localparam logic [7:0] LP_SMP_CNT = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_D0 = 2'd0,
        GOT_D0  = 2'd1,
        GOT_D1  = 2'd2,
        GOT_D2  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_com;
    logic [7:0]  r_fnd;
    logic [7:0]  r_cnt;
    logic [3:0]  r_d0, r_d1, r_d2;
    logic [13:0] r_value;
    logic        r_valid;
    logic        r_error;

    logic        w_smp;
    logic        w_one_cold;
    logic [1:0]  w_pos;
    logic        w_dig_ok;
    logic [3:0]  w_dig;
    logic        w_cap;
    logic        w_load;
    logic        w_err;
    logic [13:0] w_value_nxt;

    // r_cnt is 0 in the first cycle a new registered pattern is visible
    always_ff @(posedge clk) begin
        if (reset) begin
            r_com <= 4'hF;
            r_fnd <= 8'hFF;
            r_cnt <= '0;
        end else begin
            r_com <= fnd_com;
            r_fnd <= fnd;
            if (fnd_com != r_com)
                r_cnt <= '0;
            else if (r_cnt != 8'hFF)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_smp = (r_cnt == LP_SMP_CNT) && (r_com != 4'hF);

    always_comb begin
        w_one_cold = 1'b1;
        w_pos      = 2'd0;
        case (r_com)
            4'b1110: w_pos = 2'd0;
            4'b1101: w_pos = 2'd1;
            4'b1011: w_pos = 2'd2;
            4'b0111: w_pos = 2'd3;
            default: w_one_cold = 1'b0;
        endcase
    end

    always_comb begin
        w_dig_ok = 1'b1;
        w_dig    = 4'd0;
        case (r_fnd[6:0])
            7'h40:   w_dig = 4'd0;
            7'h79:   w_dig = 4'd1;
            7'h24:   w_dig = 4'd2;
            7'h30:   w_dig = 4'd3;
            7'h19:   w_dig = 4'd4;
            7'h12:   w_dig = 4'd5;
            7'h02:   w_dig = 4'd6;
            7'h78:   w_dig = 4'd7;
            7'h00:   w_dig = 4'd8;
            7'h10:   w_dig = 4'd9;
            default: w_dig_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= WAIT_D0;
        else
            r_state <= w_state_nxt;
    end

    // While idle, only digit_1 is of interest; everything else is scan noise
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        if (w_smp) begin
            case (r_state)
                WAIT_D0: begin
                    if (w_one_cold && w_pos == 2'd0) begin
                        if (w_dig_ok) begin
                            w_cap       = 1'b1;
                            w_state_nxt = GOT_D0;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
                GOT_D0: begin
                    if (w_one_cold && w_dig_ok && w_pos == 2'd1) begin
                        w_cap       = 1'b1;
                        w_state_nxt = GOT_D1;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = WAIT_D0;
                    end
                end
                GOT_D1: begin
                    if (w_one_cold && w_dig_ok && w_pos == 2'd2) begin
                        w_cap       = 1'b1;
                        w_state_nxt = GOT_D2;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = WAIT_D0;
                    end
                end
                GOT_D2: begin
                    w_state_nxt = WAIT_D0;
                    if (w_one_cold && w_dig_ok && w_pos == 2'd3)
                        w_load = 1'b1;
                    else
                        w_err = 1'b1;
                end
                default: w_state_nxt = WAIT_D0;
            endcase
        end
    end

    assign w_value_nxt = 14'(w_dig) * 14'd1000 + 14'(r_d2) * 14'd100
                       + 14'(r_d1) * 14'd10 + 14'(r_d0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d0    <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_valid <= w_load;
            r_error <= w_err;
            if (w_cap) begin
                case (w_pos)
                    2'd0:    r_d0 <= w_dig;
                    2'd1:    r_d1 <= w_dig;
                    2'd2:    r_d2 <= w_dig;
                    default: ;
                endcase
            end
            if (w_load)
                r_value <= w_value_nxt;
        end
    end

    assign o_value = r_value;
    assign o_valid = r_valid;
    assign o_error = r_error;

`ifdef FND_SCAN_RECEIVER_DP_EN
    logic [2:0] r_dp_cap;
    logic [3:0] r_dp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dp_cap <= '0;
            r_dp     <= '0;
        end else begin
            if (w_cap) begin
                case (w_pos)
                    2'd0:    r_dp_cap[0] <= ~r_fnd[7];
                    2'd1:    r_dp_cap[1] <= ~r_fnd[7];
                    2'd2:    r_dp_cap[2] <= ~r_fnd[7];
                    default: ;
                endcase
            end
            if (w_load)
                r_dp <= {~r_fnd[7], r_dp_cap};
        end
    end

    assign o_dp = r_dp;
`else
    logic w_unused_dp;
    assign w_unused_dp = r_fnd[7];
    assign o_dp        = 4'd0;
`endif

endmodule

// File: tb/tb_fnd_scan_receiver.sv
// Scan-level bench for fnd_scan_receiver: directed scenarios plus randomized scans vs. a frame-level model.
module tb_fnd_scan_receiver;

    localparam int STABLE = 4;
    localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    localparam logic [3:0] COMS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  fnd_com = 4'hF;
    logic [7:0]  fnd = 8'hFF;
    logic [13:0] o_value;
    logic        o_valid;
    logic        o_error;
    logic [3:0]  o_dp;

    always #5 clk = ~clk;

    fnd_scan_receiver #(.STABLE_CYCLES(STABLE)) dut (
        .clk     (clk),
        .reset   (reset),
        .fnd_com (fnd_com),
        .fnd     (fnd),
        .o_value (o_value),
        .o_valid (o_valid),
        .o_error (o_error),
        .o_dp    (o_dp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int mon_valid = 0, mon_err = 0, mon_both = 0, mon_valid_cyc = -1;
    always @(negedge clk) begin
        if (o_valid) begin
            mon_valid++;
            mon_valid_cyc = cyc;
        end
        if (o_error) mon_err++;
        if (o_valid && o_error) mon_both++;
    end

    // Frame-level reference: digits received so far, last value, pulse counts
    int          m_have = 0;
    int          m_dig [4];
    logic [3:0]  m_dp_cap = 4'd0;
    logic [13:0] m_value = 14'd0;
    logic [3:0]  m_dp = 4'd0;
    int          m_valid = 0, m_err = 0;
    logic [3:0]  last_com = 4'hF;

    function automatic int seg_digit(input logic [7:0] s);
        logic [7:0] c;
        for (int i = 0; i < 10; i++) begin
            c = SEG[i];
            if (c[6:0] == s[6:0]) return i;
        end
        return -1;
    endfunction

    function automatic int com_pos(input logic [3:0] c);
        for (int i = 0; i < 4; i++)
            if (COMS[i] == c) return i;
        return (c == 4'hF) ? -2 : -1;
    endfunction

    task automatic model_sample(input logic [3:0] com, input logic [7:0] seg);
        int p, d;
        p = com_pos(com);
        d = seg_digit(seg);
        if (p == -2) return;
        if (m_have == 0) begin
            if (p == 0) begin
                if (d >= 0) begin
                    m_dig[0] = d;
                    m_dp_cap[0] = ~seg[7];
                    m_have = 1;
                end else m_err++;
            end
        end else if (p == m_have && d >= 0) begin
            m_dig[p] = d;
            m_dp_cap[p] = ~seg[7];
            m_have++;
            if (m_have == 4) begin
                m_value = 14'(m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0]);
`ifdef FND_SCAN_RECEIVER_DP_EN
                m_dp = m_dp_cap;
`else
                m_dp = 4'd0;
`endif
                m_valid++;
                m_have = 0;
            end
        end else begin
            m_err++;
            m_have = 0;
        end
    endtask

    task automatic model_reset();
        m_have   = 0;
        m_value  = 14'd0;
        m_dp     = 4'd0;
        m_dp_cap = 4'd0;
    endtask

    task automatic dwell(input logic [3:0] com, input logic [7:0] seg, input int len);
        if (com == last_com) begin
            fnd_com = 4'hF;
            fnd     = 8'hFF;
            @(negedge clk);
        end
        fnd_com  = com;
        fnd      = seg;
        last_com = com;
        if (len >= STABLE) model_sample(com, seg);
        repeat (len) @(negedge clk);
    endtask

    task automatic scan(input int value, input int len, input logic [3:0] dpm);
        logic [7:0] s;
        int v;
        v = value;
        for (int k = 0; k < 4; k++) begin
            s = SEG[v % 10];
            s[7] = ~dpm[k];
            dwell(COMS[k], s, len);
            v = v / 10;
        end
    endtask

    task automatic settle();
        fnd_com  = 4'hF;
        fnd      = 8'hFF;
        last_com = 4'hF;
        repeat (STABLE + 3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fnd_com = 4'hF;
        fnd = 8'hFF;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (o_value !== 14'd0) begin n_fail++; $display("FAIL reset_value got %0d want 0", o_value); end
        n_checks++;
        if (o_valid !== 1'b0 || o_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses got valid=%b error=%b want 0 0", o_valid, o_error);
        end
        n_checks++;
        if (o_dp !== 4'd0) begin n_fail++; $display("FAIL reset_dp got %b want 0000", o_dp); end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_1234();
        int t0;
        dwell(4'b1110, SEG[4], 10);
        dwell(4'b1101, SEG[3], 10);
        dwell(4'b1011, SEG[2], 10);
        t0 = cyc;
        dwell(4'b0111, SEG[1], 10);
        settle();
        n_checks++;
        if (o_value !== 14'd1234 || m_value !== 14'd1234) begin
            n_fail++; $display("FAIL scan_1234 got %0d model %0d want 1234", o_value, m_value);
        end
        n_checks++;
        if (mon_valid != m_valid || mon_err != m_err) begin
            n_fail++; $display("FAIL scan_1234_pulses got v=%0d e=%0d want v=%0d e=%0d", mon_valid, mon_err, m_valid, m_err);
        end
        n_checks++;
        if (mon_valid_cyc != t0 + STABLE + 1) begin
            n_fail++; $display("FAIL scan_1234_latency got cycle %0d want %0d", mon_valid_cyc, t0 + STABLE + 1);
        end
    endtask

    task automatic test_9999_0000();
        scan(9999, 6, 4'd0);
        settle();
        n_checks++;
        if (o_value !== 14'd9999 || mon_valid != m_valid) begin
            n_fail++; $display("FAIL scan_9999 got %0d (v=%0d) want 9999 (v=%0d)", o_value, mon_valid, m_valid);
        end
        scan(0, 7, 4'd0);
        settle();
        n_checks++;
        if (o_value !== 14'd0 || mon_valid != m_valid || mon_err != m_err) begin
            n_fail++; $display("FAIL scan_0000 got %0d v=%0d e=%0d want 0 v=%0d e=%0d", o_value, mon_valid, mon_err, m_valid, m_err);
        end
    endtask

    task automatic test_bad_code();
        int v0;
        v0 = mon_valid;
        dwell(4'b1110, SEG[3], 6);
        dwell(4'b1101, 8'h88, 6);
        settle();
        n_checks++;
        if (mon_err != m_err || mon_valid != v0 || o_value !== m_value) begin
            n_fail++; $display("FAIL bad_code got e=%0d v=%0d val=%0d want e=%0d v=%0d val=%0d", mon_err, mon_valid, o_value, m_err, v0, m_value);
        end
        scan(42, 6, 4'd0);
        settle();
        n_checks++;
        if (o_value !== 14'd42 || mon_valid != m_valid) begin
            n_fail++; $display("FAIL after_bad_code got %0d want 42", o_value);
        end
    endtask

    task automatic test_short_dwell();
        int v0, e0;
        logic [13:0] val0;
        v0 = mon_valid; e0 = mon_err; val0 = o_value;
        scan(8765, STABLE - 1, 4'd0);
        settle();
        n_checks++;
        if (mon_valid != v0 || mon_err != e0 || o_value !== val0) begin
            n_fail++; $display("FAIL short_dwell got v=%0d e=%0d val=%0d want v=%0d e=%0d val=%0d", mon_valid, mon_err, o_value, v0, e0, val0);
        end
    endtask

    task automatic test_order_blank();
        dwell(4'b1110, SEG[1], 6);
        dwell(4'b1011, SEG[2], 6);
        settle();
        n_checks++;
        if (mon_err != m_err) begin
            n_fail++; $display("FAIL out_of_order got e=%0d want %0d", mon_err, m_err);
        end
        dwell(4'b1110, SEG[5], 6);
        dwell(4'b1111, 8'hFF, 6);
        dwell(4'b1101, SEG[6], 6);
        dwell(4'b1011, SEG[7], 6);
        dwell(4'b0111, SEG[8], 6);
        settle();
        n_checks++;
        if (o_value !== 14'd8765 || mon_valid != m_valid || mon_err != m_err) begin
            n_fail++; $display("FAIL blank_continue got %0d v=%0d e=%0d want 8765 v=%0d e=%0d", o_value, mon_valid, mon_err, m_valid, m_err);
        end
    endtask

    task automatic test_bad_com();
        dwell(4'b1110, SEG[1], 6);
        dwell(4'b1100, SEG[1], STABLE);
        settle();
        n_checks++;
        if (mon_err != m_err || mon_valid != m_valid) begin
            n_fail++; $display("FAIL bad_com got e=%0d v=%0d want e=%0d v=%0d", mon_err, mon_valid, m_err, m_valid);
        end
    endtask

    task automatic test_reset_midframe();
        int v0, e0;
        dwell(4'b1110, SEG[8], 8);
        dwell(4'b1101, SEG[7], 7);
        dwell(4'b1011, SEG[6], 6);
        v0 = mon_valid; e0 = mon_err;
        reset = 1'b1;
        fnd_com = 4'hF; fnd = 8'hFF; last_com = 4'hF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (mon_valid != v0 || mon_err != e0 || o_value !== 14'd0) begin
            n_fail++; $display("FAIL reset_midframe got v=%0d e=%0d val=%0d want v=%0d e=%0d val=0", mon_valid, mon_err, o_value, v0, e0);
        end
        scan(5678, 6, 4'd0);
        settle();
        n_checks++;
        if (o_value !== 14'd5678 || mon_valid != v0 + 1 || mon_err != e0) begin
            n_fail++; $display("FAIL after_reset got %0d v=%0d e=%0d want 5678 v=%0d e=%0d", o_value, mon_valid, mon_err, v0 + 1, e0);
        end
    endtask

    task automatic test_dp();
        logic [3:0] want;
`ifdef FND_SCAN_RECEIVER_DP_EN
        want = 4'b0001;
`else
        want = 4'b0000;
`endif
        scan(1230, 6, 4'b0001);
        settle();
        n_checks++;
        if (o_dp !== want || o_dp !== m_dp || o_value !== 14'd1230) begin
            n_fail++; $display("FAIL dp got dp=%b val=%0d want dp=%b val=1230", o_dp, o_value, want);
        end
    endtask

    task automatic test_random();
        logic [7:0] s;
        logic [3:0] c;
        int v, sel;
        for (int it = 1; it <= 300; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                v = $urandom_range(0, 9999);
                for (int k = 0; k < 4; k++) begin
                    s = SEG[v % 10];
                    s[7] = 1'($urandom_range(0, 1));
                    dwell(COMS[k], s, $urandom_range(STABLE - 1, STABLE + 3));
                    v = v / 10;
                end
            end else begin
                sel = $urandom_range(0, 5);
                c = (sel < 4) ? COMS[sel] : (sel == 4) ? 4'hF : 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) begin
                    s = SEG[$urandom_range(0, 9)];
                    s[7] = 1'($urandom_range(0, 1));
                end else begin
                    s = 8'($urandom_range(0, 255));
                end
                dwell(c, s, $urandom_range(1, STABLE + 2));
            end
            if (it % 25 == 0) begin
                settle();
                n_checks++;
                if (mon_valid != m_valid || mon_err != m_err) begin
                    n_fail++; $display("FAIL random_pulses it=%0d got v=%0d e=%0d want v=%0d e=%0d", it, mon_valid, mon_err, m_valid, m_err);
                end
                n_checks++;
                if (o_value !== m_value || o_dp !== m_dp) begin
                    n_fail++; $display("FAIL random_value it=%0d got %0d dp=%b want %0d dp=%b", it, o_value, o_dp, m_value, m_dp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_1234();
        test_9999_0000();
        test_bad_code();
        test_short_dwell();
        test_order_blank();
        test_bad_com();
        test_reset_midframe();
        test_dp();
        test_random();
        n_checks++;
        if (mon_both != 0) begin
            n_fail++; $display("FAIL valid_error_overlap got %0d cycles want 0", mon_both);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_scan_receiver.md
FND_SCAN_RECEIVER -- requirements
Module: fnd_scan_receiver

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive cycles a digit-enable pattern must hold before its segments are sampled (legal range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fnd_com  input  4  active-low digit enable; 1110 selects digit_1, 1101 digit_10, 1011 digit_100, 0111 digit_1000.
REQ-005 SHALL have port fnd  input  8  active-low segment pattern; bit7 is the decimal point.
REQ-006 SHALL have port o_value  output  14  last fully received decimal value, 0..9999.
REQ-007 SHALL have port o_valid  output  1  one-cycle pulse when o_value updates.
REQ-008 SHALL have port o_error  output  1  one-cycle pulse when a frame is aborted.
REQ-009 SHALL have port o_dp  output  4  decimal-point flags for digits 3..0 of the last valid frame.

Function
REQ-010 SHALL register fnd_com and fnd once; every rule below applies to the registered copies.
REQ-011 SHALL count dwell cycles: the counter clears when registered fnd_com changes and increments (saturating) while it is unchanged.
REQ-012 SHALL sample a digit exactly once per dwell, in the cycle the counter reaches STABLE_CYCLES-1, and only for a one-cold fnd_com pattern.
REQ-013 SHALL decode segments (bit7 masked) 0xC0,F9,A4,B0,99,92,82,F8,80,90 to digits 0..9; any other code is invalid.
REQ-014 SHALL implement FSM WAIT_D0 -> GOT_D0 -> GOT_D1 -> GOT_D2 -> WAIT_D0, advancing on a valid sample of digit_1, digit_10, digit_100 and digit_1000 respectively.
REQ-015 SHALL ignore samples of any digit other than digit_1 while in WAIT_D0, without flagging an error.
REQ-016 SHALL treat, in states GOT_D0..GOT_D2, a sample of a digit other than the expected successor as out-of-order.
REQ-017 SHALL, on an out-of-order sample or an invalid code in any state except WAIT_D0 idle, pulse o_error for one cycle, discard the partial frame and return to WAIT_D0.
REQ-018 SHALL treat an invalid code on digit_1 in WAIT_D0 as an error pulse, with the FSM staying in WAIT_D0.
REQ-019 SHALL treat fnd_com=1111 (blank) as a pattern change that never samples and never errors.
REQ-020 SHALL treat any other non-one-cold fnd_com, once stable for STABLE_CYCLES, as an error under REQ-017.
REQ-021 SHALL, in the cycle after the digit_1000 sample, load o_value = d1000*1000 + d100*100 + d10*10 + d1 and o_dp, and pulse o_valid.
REQ-022 SHALL hold o_value and o_dp between valid frames; o_valid and o_error are never high in the same cycle.
REQ-023 SHALL produce a received frame whose first sample is digit_1 (1110), not one starting mid-scan.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, set: FSM=WAIT_D0, dwell counter=0, input registers to all ones, captured digits=0, o_value=0, o_dp=0, o_valid=0, o_error=0.
REQ-025 SHALL discard any partial frame on reset, with no o_valid or o_error pulse.
REQ-026 SHALL use the first cycle after reset release as the start of normal sampling.

Configuration
REQ-027 SHALL gate decimal-point capture with macro FND_SCAN_RECEIVER_DP_EN.
REQ-028 SHALL, with FND_SCAN_RECEIVER_DP_EN defined, capture o_dp[n] = ~fnd[7] for digit n of each valid frame.
REQ-029 SHALL, with FND_SCAN_RECEIVER_DP_EN undefined, tie o_dp constant 0; decoding ignores bit7 in both builds.

Verification
REQ-030 SHALL cover: a scan of 1234 with 10-cycle dwell per digit -> o_valid pulse and o_value=1234 (0x4D2), o_error=0.
REQ-031 SHALL cover: a scan of 9999, then 0000 -> o_value=9999, then o_value=0, with one o_valid per frame.
REQ-032 SHALL cover: fnd=0x88 on digit_10 -> o_error pulse, no o_valid, o_value unchanged; the next clean frame of 0042 -> o_value=42.
REQ-033 SHALL cover: a 3-cycle dwell with STABLE_CYCLES=4 -> no samples, no o_valid, no o_error.
REQ-034 SHALL cover: 1110 then 1011 -> o_error pulse; 1110 then 1111 (blank) then 1101 -> the frame continues normally.
REQ-035 SHALL cover: reset asserted after digit_100 of 5678, then a full 5678 scan -> one o_valid with o_value=5678; with DP_EN, fnd=0x40 on digit_1 -> o_dp=0001.
